// File: rtl/pipeline_pkg.sv
// Shared definitions for the MEM-stage data-memory access controller:
// FSM state encoding and default bus/timeout parameters.
package pipeline_pkg;

  // Access controller FSM encoding
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_DONE = 2'd2
  } mem_state_t;

  localparam int DATA_W_DEF      = 32;
  localparam int ADDR_W_DEF      = 32;
  localparam int TIMEOUT_CYC_DEF = 64;

endpackage

// File: rtl/dmem_timeout_cnt.sv
// Saturating WAIT-cycle counter for the data-memory controller.
// Counts from 0 up to MAX-1 and then holds; tc flags the terminal value.
module dmem_timeout_cnt
  import pipeline_pkg::*;
#(
  parameter int MAX = TIMEOUT_CYC_DEF
) (
  input  logic clk,
  input  logic arst_n,
  input  logic clr,
  input  logic en,
  output logic tc
);

  localparam int CNT_W = (MAX > 1) ? $clog2(MAX) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(MAX - 1);

  logic [CNT_W-1:0] count;

  // Clear has priority; otherwise count up while enabled, never wrapping
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (en && (count != LAST)) begin
      count <= count + CNT_W'(1);
    end
  end

  assign tc = (count == LAST);

endmodule

// File: rtl/dmem_stall_ctrl.sv
// MEM-stage data-memory access controller. Issues one req/ack transaction
// per load/store sitting in the MEM stage and freezes the pipeline (pc_w,
// pipeline_en low) until the access completes or times out.
//
// Bus handshake: bus_req rises on the edge after an access is detected and
// stays high, with bus_addr/bus_wdata/bus_we stable, until the memory returns
// a one-cycle bus_ack (bus_rdata valid in that same cycle) or the WAIT
// timeout expires. bus_ack seen while bus_req is low is ignored.
module dmem_stall_ctrl
  import pipeline_pkg::*;
#(
  parameter int DATA_W      = DATA_W_DEF,
  parameter int ADDR_W      = ADDR_W_DEF,
  parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
  input  logic              clk,
  input  logic              arst_n,
  input  logic              mem_read_mem,
  input  logic              mem_write_mem,
  input  logic [ADDR_W-1:0] addr_mem,
  input  logic [DATA_W-1:0] wdata_mem,
  output logic [DATA_W-1:0] rdata_mem,
  output logic              bus_req,
  output logic              bus_we,
  output logic [ADDR_W-1:0] bus_addr,
  output logic [DATA_W-1:0] bus_wdata,
  input  logic              bus_ack,
  input  logic [DATA_W-1:0] bus_rdata,
  output logic              pc_w,
  output logic              pipeline_en,
  output logic              busy,
  output logic              err,
  output logic [1:0]        fsm_state
);

  mem_state_t state;
  mem_state_t state_nxt;

  logic access;
  logic cnt_clr;
  logic cnt_en;
  logic cnt_tc;

  // A store wins when both strobes are high
  assign access = mem_read_mem | mem_write_mem;

  // Counter restarts on the detect cycle and runs only while waiting
  assign cnt_clr = (state == ST_IDLE) && access;
  assign cnt_en  = (state == ST_WAIT);

  dmem_timeout_cnt #(
    .MAX (TIMEOUT_CYC)
  ) u_timeout_cnt (
    .clk    (clk),
    .arst_n (arst_n),
    .clr    (cnt_clr),
    .en     (cnt_en),
    .tc     (cnt_tc)
  );

  // State register
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state: DONE always returns to IDLE so an access is issued only once
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (access)             state_nxt = ST_WAIT;
      ST_WAIT: if (bus_ack || cnt_tc)  state_nxt = ST_DONE;
      ST_DONE:                         state_nxt = ST_IDLE;
      default:                         state_nxt = ST_IDLE;
    endcase
  end

  // Pipeline control decode; the freeze starts combinationally on detect
  always_comb begin
    pc_w        = 1'b1;
    pipeline_en = 1'b1;
    busy        = 1'b0;
    case (state)
      ST_IDLE: begin
        pc_w        = ~access;
        pipeline_en = ~access;
      end
      ST_WAIT: begin
        pc_w        = 1'b0;
        pipeline_en = 1'b0;
        busy        = 1'b1;
      end
      default: begin
        pc_w        = 1'b1;
        pipeline_en = 1'b1;
        busy        = 1'b0;
      end
    endcase
  end

  // Bus request, address/data latch, read capture and timeout pulse
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      bus_req   <= 1'b0;
      bus_we    <= 1'b0;
      bus_addr  <= '0;
      bus_wdata <= '0;
      rdata_mem <= '0;
      err       <= 1'b0;
    end else begin
      err <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (access) begin
            bus_addr  <= addr_mem;
            bus_wdata <= wdata_mem;
            bus_we    <= mem_write_mem;
            bus_req   <= 1'b1;
          end
        end
        ST_WAIT: begin
          // An ack in the terminal cycle still completes the access cleanly
          if (bus_ack) begin
            if (!bus_we) begin
              rdata_mem <= bus_rdata;
            end
            bus_req <= 1'b0;
          end else if (cnt_tc) begin
            rdata_mem <= '0;
            err       <= 1'b1;
            bus_req   <= 1'b0;
          end
        end
        default: begin
          bus_req <= 1'b0;
        end
      endcase
    end
  end

  assign fsm_state = state;

endmodule

// File: tb/tb_dmem_stall_ctrl.sv
// Bench for dmem_stall_ctrl: table of accesses with expected stall/err,
// a scoreboard queue of expected rdata_mem values, and hand-written
// sequences for timeout, back-to-back, stray ack and mid-WAIT reset.
module tb_dmem_stall_ctrl;

  localparam int TMO = 64;

  logic        clk;
  logic        arst_n;
  logic        mem_read_mem;
  logic        mem_write_mem;
  logic [31:0] addr_mem;
  logic [31:0] wdata_mem;
  logic [31:0] rdata_mem;
  logic        bus_req;
  logic        bus_we;
  logic [31:0] bus_addr;
  logic [31:0] bus_wdata;
  logic        bus_ack;
  logic [31:0] bus_rdata;
  logic        pc_w;
  logic        pipeline_en;
  logic        busy;
  logic        err;
  logic [1:0]  fsm_state;

  typedef struct {
    logic        rd;
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          k;          // ack delay in WAIT cycles, -1 means never
    logic [31:0] rdat;
    int          exp_stall;
    logic        exp_err;
  } vec_t;

  vec_t        vecs[6];
  logic [31:0] exp_q[$];
  logic [31:0] model_rdata;
  int          n_cmp;
  int          n_bad;
  int          req_rises;
  int          n_issued;

  dmem_stall_ctrl #(
    .DATA_W      (32),
    .ADDR_W      (32),
    .TIMEOUT_CYC (TMO)
  ) dut (
    .clk           (clk),
    .arst_n        (arst_n),
    .mem_read_mem  (mem_read_mem),
    .mem_write_mem (mem_write_mem),
    .addr_mem      (addr_mem),
    .wdata_mem     (wdata_mem),
    .rdata_mem     (rdata_mem),
    .bus_req       (bus_req),
    .bus_we        (bus_we),
    .bus_addr      (bus_addr),
    .bus_wdata     (bus_wdata),
    .bus_ack       (bus_ack),
    .bus_rdata     (bus_rdata),
    .pc_w          (pc_w),
    .pipeline_en   (pipeline_en),
    .busy          (busy),
    .err           (err),
    .fsm_state     (fsm_state)
  );

  // Clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Count request bursts to catch duplicate issues
  initial req_rises = 0;
  always @(posedge bus_req) req_rises++;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Several cycles with no access: pipeline free, no request, no err
  task automatic idle_check(input int n, input string tag);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      check(tag, {27'd0, pc_w, pipeline_en, bus_req, busy, err}, 32'h18);
      check({tag, "_state"}, {30'd0, fsm_state}, 32'd0);
      @(posedge clk);
      #1;
    end
  endtask

  // Drive one access from the IDLE detect cycle through DONE
  task automatic do_access(input vec_t v, input string tag);
    logic [31:0] exp_rd;
    int          stall;
    int          waitc;
    int          errs;
    logic        held_ok;
    logic        done;
    if (v.k < 0)   exp_rd = 32'd0;
    else if (v.wr) exp_rd = model_rdata;
    else           exp_rd = v.rdat;
    model_rdata = exp_rd;
    exp_q.push_back(exp_rd);
    n_issued++;
    mem_read_mem  = v.rd;
    mem_write_mem = v.wr;
    addr_mem      = v.addr;
    wdata_mem     = v.wdata;
    stall   = 0;
    waitc   = 0;
    errs    = 0;
    held_ok = 1'b1;
    done    = 1'b0;
    for (int c = 0; c < TMO + 40; c++) begin
      @(negedge clk);
      if (err) errs++;
      if (pipeline_en) begin
        done = 1'b1;
        break;
      end
      stall++;
      if (pc_w) held_ok = 1'b0;
      if (bus_req) begin
        waitc++;
        if (!busy || bus_addr !== v.addr || bus_we !== v.wr || bus_wdata !== v.wdata)
          held_ok = 1'b0;
      end
      if (v.k > 0 && waitc == v.k) begin
        bus_ack   = 1'b1;
        bus_rdata = v.rdat;
      end else begin
        bus_rdata = $urandom;
      end
      @(posedge clk);
      #1;
      bus_ack = 1'b0;
    end
    check({tag, "_done_reached"}, {31'd0, done}, 32'd1);
    check({tag, "_stall"}, stall, v.exp_stall);
    check({tag, "_wait_held"}, {31'd0, held_ok}, 32'd1);
    check({tag, "_done_ctl"}, {28'd0, pc_w, pipeline_en, busy, bus_req}, 32'hC);
    check({tag, "_err"}, {31'd0, err}, {31'd0, v.exp_err});
    check({tag, "_err_pulses"}, errs, v.exp_err ? 32'd1 : 32'd0);
    check({tag, "_rdata"}, rdata_mem, exp_q.pop_front());
    @(posedge clk);
    #1;
    mem_read_mem  = 1'b0;
    mem_write_mem = 1'b0;
  endtask

  task automatic print_summary;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
  endtask

  // Watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time bound");
    n_bad++;
    print_summary();
    $fatal(1, "watchdog");
  end

  // Main sequence
  initial begin
    vec_t v;
    int   rises0;
    n_cmp         = 0;
    n_bad         = 0;
    n_issued      = 0;
    model_rdata   = 32'd0;
    arst_n        = 1'b0;
    mem_read_mem  = 1'b0;
    mem_write_mem = 1'b0;
    addr_mem      = 32'd0;
    wdata_mem     = 32'd0;
    bus_ack       = 1'b0;
    bus_rdata     = 32'd0;

    //         rd    wr    addr          wdata         k  rdat          stall err
    vecs[0] = '{1'b1, 1'b0, 32'h0000_0100, 32'h0000_0000, 3, 32'hDEAD_BEEF, 4, 1'b0};
    vecs[1] = '{1'b0, 1'b1, 32'h0000_0200, 32'h1234_5678, 1, 32'hFFFF_0000, 2, 1'b0};
    vecs[2] = '{1'b1, 1'b1, 32'h0000_0300, 32'hA5A5_A5A5, 2, 32'hBAD0_BAD0, 3, 1'b0};
    vecs[3] = '{1'b1, 1'b0, 32'h0000_0104, 32'h0000_0000, 1, 32'hCAFE_F00D, 2, 1'b0};
    vecs[4] = '{1'b1, 1'b0, 32'h0000_0108, 32'h0000_0000, 5, 32'h0F0F_1234, 6, 1'b0};
    vecs[5] = '{1'b0, 1'b1, 32'h0000_020C, 32'h55AA_55AA, 4, 32'h7777_7777, 5, 1'b0};

    // Reset values while held in reset
    #13;
    check("rst_regs", {28'd0, bus_req, bus_we, err, busy}, 32'd0);
    check("rst_ctl", {30'd0, pc_w, pipeline_en}, 32'd3);
    check("rst_addr", bus_addr, 32'd0);
    check("rst_wdata", bus_wdata, 32'd0);
    check("rst_rdata", rdata_mem, 32'd0);
    check("rst_state", {30'd0, fsm_state}, 32'd0);
    @(negedge clk);
    arst_n = 1'b1;
    @(posedge clk);
    #1;

    idle_check(10, "idle_after_reset");

    // Table: loads, stores and the read+write overlap case
    for (int i = 0; i < 6; i++) begin
      do_access(vecs[i], $sformatf("vec%0d", i));
      idle_check(1, $sformatf("vec%0d_idle", i));
    end

    // No ack: timeout forces completion with zero data and one err pulse
    v = '{1'b1, 1'b0, 32'h0000_0400, 32'h0, -1, 32'h0, TMO + 1, 1'b1};
    do_access(v, "timeout");
    idle_check(1, "timeout_idle");
    v = '{1'b1, 1'b0, 32'h0000_0404, 32'h0, 2, 32'h1357_9BDF, 3, 1'b0};
    do_access(v, "after_timeout");
    idle_check(1, "after_timeout_idle");

    // Ack exactly in the terminal WAIT cycle: ack wins, no err
    v = '{1'b1, 1'b0, 32'h0000_0408, 32'h0, TMO, 32'h2468_ACE0, TMO + 1, 1'b0};
    do_access(v, "ack_at_tc");
    idle_check(1, "ack_at_tc_idle");

    // Back-to-back loads: exactly two request bursts
    rises0 = req_rises;
    v = '{1'b1, 1'b0, 32'h0000_0500, 32'h0, 1, 32'hAAAA_0001, 2, 1'b0};
    do_access(v, "b2b_a");
    v = '{1'b1, 1'b0, 32'h0000_0504, 32'h0, 1, 32'hAAAA_0002, 2, 1'b0};
    do_access(v, "b2b_b");
    idle_check(2, "b2b_idle");
    check("b2b_req_bursts", req_rises - rises0, 32'd2);

    // Random accesses with random ack delay
    for (int i = 0; i < 4; i++) begin
      v.rd        = 1'b1;
      v.wr        = 1'($urandom_range(0, 1));
      v.addr      = {$urandom_range(0, 32'hFFFF), 2'b00};
      v.wdata     = $urandom;
      v.k         = $urandom_range(1, 6);
      v.rdat      = $urandom;
      v.exp_stall = v.k + 1;
      v.exp_err   = 1'b0;
      do_access(v, $sformatf("rnd%0d", i));
      idle_check(1, $sformatf("rnd%0d_idle", i));
    end

    // Stray ack while idle has no effect
    for (int i = 0; i < 3; i++) begin
      bus_ack   = 1'b1;
      bus_rdata = $urandom;
      @(negedge clk);
      check("stray_ack_ctl", {28'd0, pc_w, pipeline_en, bus_req, busy}, 32'hC);
      @(posedge clk);
      #1;
    end
    bus_ack = 1'b0;
    @(negedge clk);
    check("stray_ack_rdata", rdata_mem, model_rdata);
    check("stray_ack_state", {30'd0, fsm_state}, 32'd0);
    @(posedge clk);
    #1;

    // Reset in the 2nd WAIT cycle, then a late ack after release
    mem_read_mem = 1'b1;
    addr_mem     = 32'h0000_0600;
    n_issued++;
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    check("rst_wait_pre_req", {31'd0, bus_req}, 32'd1);
    check("rst_wait_pre_state", {30'd0, fsm_state}, 32'd1);
    @(negedge clk);
    arst_n       = 1'b0;
    mem_read_mem = 1'b0;
    model_rdata  = 32'd0;
    #1;
    check("rst_wait_req", {31'd0, bus_req}, 32'd0);
    check("rst_wait_state", {30'd0, fsm_state}, 32'd0);
    check("rst_wait_regs", {29'd0, bus_we, err, busy}, 32'd0);
    check("rst_wait_ctl", {30'd0, pc_w, pipeline_en}, 32'd3);
    check("rst_wait_addr", bus_addr, 32'd0);
    check("rst_wait_rdata", rdata_mem, 32'd0);
    @(negedge clk);
    arst_n = 1'b1;
    @(posedge clk);
    #1;
    bus_ack   = 1'b1;
    bus_rdata = 32'hFEED_FACE;
    @(posedge clk);
    #1;
    bus_ack = 1'b0;
    idle_check(3, "late_ack_idle");
    check("late_ack_rdata", rdata_mem, 32'd0);

    check("total_req_bursts", req_rises, n_issued);
    check("scoreboard_empty", exp_q.size(), 32'd0);

    print_summary();
    $finish;
  end

endmodule
